muldiv_ctrl: RTL and testbench

- Controller for the multiply/divide resource and the architectural HI/LO registers.
- Sits beside the EXE stage. EXE issues MULT/MULTU/DIV/DIVU through a valid/ready handshake.
- The block sequences a pipelined multiplier and a 32-iteration restoring divider, then commits results to HI/LO.
- Serves MFHI/MFLO reads and MTHI/MTLO writes, and raises busy so decode/EXE can stall HI/LO consumers.

---
 rtl/muldiv_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU.
// Multiplies commit MUL_LAT cycles after accept. Divides run DIV_ITER
// restoring iterations on unsigned magnitudes, then apply a sign fix-up.
// MTHI/MTLO writes land only while idle.
// Optional: `define MULDIV_CANCEL_EN lets `cancel` flush an in-flight op
// with no HI/LO write. When it is undefined, `cancel` is ignored.

// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if the partial remainder is large enough.
module muldiv_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        ge;

    // 34-bit subtract so that the top bit is a clean borrow flag
    always_comb begin
        rem_sh = {rem_i, quo_i[31]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_i};
        ge     = ~diff[33];
        rem_o  = ge ? diff[31:0] : rem_sh[31:0];
        quo_o  = {quo_i[30:0], ge};
    end
endmodule

module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        mt_hi_we,
    input  logic        mt_lo_we,
    input  logic [31:0] mt_wdata,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

    // req_op bit positions
    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;      // raw src1, also the div-by-zero HI value
    logic [31:0] b_q, b_d;      // raw src2
    logic        sgn_q, sgn_d;  // signed multiply
    logic [31:0] quo_q, quo_d;  // dividend magnitude shifting out, quotient in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;  // divisor magnitude
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    logic        op_ok;
    logic        accept;
    logic        is_div_s;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] step_rem, step_quo;

    muldiv_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Operands are sign- or zero-extended to 64 bits; the low 64 bits of
    // the product are then correct for both mult and multu.
    always_comb begin
        mul_a = {{32{sgn_q & a_q[31]}}, a_q};
        mul_b = {{32{sgn_q & b_q[31]}}, b_q};
        prod  = mul_a * mul_b;
    end

`ifndef MULDIV_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    // Next-state, HI/LO update, operand capture and iteration control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        is_div_s = 1'b0;

        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        op_ok     = (req_op != 4'd0) && ((req_op & (req_op - 4'd1)) == 4'd0);
        accept    = req_valid && req_ready && op_ok;

        unique case (state_q)
            S_IDLE: begin
                if (mt_hi_we) hi_d = mt_wdata;
                if (mt_lo_we) lo_d = mt_wdata;
                if (accept) begin
                    a_d   = req_src1;
                    b_d   = req_src2;
                    cnt_d = 6'd0;
                    if (req_op[OP_MULT] || req_op[OP_MULTU]) begin
                        state_d = S_MUL;
                        sgn_d   = req_op[OP_MULT];
                    end else begin
                        state_d  = S_DIV;
                        is_div_s = req_op[OP_DIV];
                        quo_d    = (is_div_s && req_src1[31]) ? (~req_src1 + 32'd1) : req_src1;
                        dvs_d    = (is_div_s && req_src2[31]) ? (~req_src2 + 32'd1) : req_src2;
                        rem_d    = 32'd0;
                        qneg_d   = is_div_s && (req_src1[31] ^ req_src2[31]);
                        rneg_d   = is_div_s && req_src1[31];
                        dz_d     = (req_src2 == 32'd0);
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MUL_LAST) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DIV_LAST) begin
                    if (dz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = qneg_q ? (~step_quo + 32'd1) : step_quo;
                        hi_d = rneg_q ? (~step_rem + 32'd1) : step_rem;
                    end
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase

`ifdef MULDIV_CANCEL_EN
        // Flush wins over a commit landing on the same edge
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif

        hi_rdata = hi_q;
        lo_rdata = lo_q;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT=2).
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_src1 = 32'd0;
    logic [31:0] req_src2 = 32'd0;
    logic        mt_hi_we = 1'b0;
    logic        mt_lo_we = 1'b0;
    logic [31:0] mt_wdata = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    int checks = 0;
    int failures = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we), .mt_wdata(mt_wdata),
        .cancel(cancel), .busy(busy), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for the accept edge, then counts cycles until idle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        cyc = 0;
        while (busy && cyc < 64) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        checks++;
        if (hi_rdata !== 32'd0 || lo_rdata !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: hi=%h lo=%h busy=%b ready=%b want 0 0 0 1",
                     hi_rdata, lo_rdata, busy, req_ready);
        end
    endtask

    task automatic test_mult();
        req_valid = 1'b1; req_op = OP_MULT; req_src1 = 32'hFFFF_FFFD; req_src2 = 32'd5;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mult_busy_e0: busy=%b ready=%b want 1 0", busy, req_ready);
        end
        step();
        checks++;
        if (busy !== 1'b1 || hi_rdata !== 32'd0) begin
            failures++;
            $display("FAIL mult_busy_e1: busy=%b hi=%h want 1 0", busy, hi_rdata);
        end
        step();
        checks++;
        if (hi_rdata !== 32'hFFFF_FFFF || lo_rdata !== 32'hFFFF_FFF1 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mult_result: hi=%h lo=%h busy=%b ready=%b want ffffffff fffffff1 0 1",
                     hi_rdata, lo_rdata, busy, req_ready);
        end
    endtask

    task automatic test_multu_mt_drop();
        req_valid = 1'b1; req_op = OP_MULTU; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'd2;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        mt_hi_we = 1'b1; mt_wdata = 32'h1234;   // while busy: must be dropped
        step();
        mt_hi_we = 1'b0;
        step();
        step();
        checks++;
        if (hi_rdata !== 32'h0000_0001 || lo_rdata !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_mt_drop: hi=%h lo=%h want 00000001 fffffffe", hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_div();
        int cyc;
        run_op(OP_DIVU, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 32 || lo_rdata !== 32'd14 || hi_rdata !== 32'd2) begin
            failures++;
            $display("FAIL divu_100_7: cycles=%0d lo=%h hi=%h want 32 e 2", cyc, lo_rdata, hi_rdata);
        end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (lo_rdata !== 32'hFFFF_FFFD || hi_rdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_m7_2: lo=%h hi=%h want fffffffd ffffffff", lo_rdata, hi_rdata);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
        checks++;
        if (lo_rdata !== 32'hFFFF_FFFD || hi_rdata !== 32'd1) begin
            failures++;
            $display("FAIL div_7_m2: lo=%h hi=%h want fffffffd 1", lo_rdata, hi_rdata);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (lo_rdata !== 32'h8000_0000 || hi_rdata !== 32'd0) begin
            failures++;
            $display("FAIL div_min_m1: lo=%h hi=%h want 80000000 0", lo_rdata, hi_rdata);
        end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, cyc);
        checks++;
        if (lo_rdata !== 32'h0FFF_FFFF || hi_rdata !== 32'hF) begin
            failures++;
            $display("FAIL divu_big: lo=%h hi=%h want 0fffffff f", lo_rdata, hi_rdata);
        end
    endtask

    task automatic test_divzero_mt();
        int cyc;
        run_op(OP_DIV, 32'd5, 32'd0, cyc);
        checks++;
        if (lo_rdata !== 32'hFFFF_FFFF || hi_rdata !== 32'd5) begin
            failures++;
            $display("FAIL div_5_0: lo=%h hi=%h want ffffffff 5", lo_rdata, hi_rdata);
        end
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, cyc);
        checks++;
        if (lo_rdata !== 32'hFFFF_FFFF || hi_rdata !== 32'hFFFF_FFFB) begin
            failures++;
            $display("FAIL div_m5_0: lo=%h hi=%h want ffffffff fffffffb", lo_rdata, hi_rdata);
        end
        mt_lo_we = 1'b1; mt_wdata = 32'hA;
        step();
        mt_lo_we = 1'b0; mt_hi_we = 1'b1; mt_wdata = 32'hB;
        step();
        mt_hi_we = 1'b0;
        checks++;
        if (lo_rdata !== 32'hA || hi_rdata !== 32'hB) begin
            failures++;
            $display("FAIL mt_seq: lo=%h hi=%h want a b", lo_rdata, hi_rdata);
        end
        mt_lo_we = 1'b1; mt_hi_we = 1'b1; mt_wdata = 32'hC;
        step();
        mt_lo_we = 1'b0; mt_hi_we = 1'b0;
        checks++;
        if (lo_rdata !== 32'hC || hi_rdata !== 32'hC) begin
            failures++;
            $display("FAIL mt_both: lo=%h hi=%h want c c", lo_rdata, hi_rdata);
        end
    endtask

    task automatic test_invalid_op();
        req_valid = 1'b1; req_op = 4'b0011; req_src1 = 32'd3; req_src2 = 32'd4;
        step();
        req_op = 4'b0000;
        step();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || lo_rdata !== 32'hC || hi_rdata !== 32'hC) begin
            failures++;
            $display("FAIL invalid_op: busy=%b lo=%h hi=%h want 0 c c", busy, lo_rdata, hi_rdata);
        end
    endtask

    task automatic test_mt_with_accept();
        mt_lo_we = 1'b1; mt_wdata = 32'h77;
        req_valid = 1'b1; req_op = OP_MULT; req_src1 = 32'd3; req_src2 = 32'd4;
        step();
        mt_lo_we = 1'b0; req_valid = 1'b0; req_op = 4'd0;
        checks++;
        if (lo_rdata !== 32'h77 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mt_accept_e0: lo=%h busy=%b want 77 1", lo_rdata, busy);
        end
        step(); step();
        checks++;
        if (lo_rdata !== 32'd12 || hi_rdata !== 32'd0) begin
            failures++;
            $display("FAIL mt_accept_result: lo=%h hi=%h want c 0", lo_rdata, hi_rdata);
        end
    endtask

    task automatic test_back_to_back();
        // EXE keeps req_valid high and presents the next op right after accept
        req_valid = 1'b1; req_op = OP_MULT; req_src1 = 32'd6; req_src2 = 32'd7;
        step();
        req_op = OP_MULTU; req_src1 = 32'h8000_0000; req_src2 = 32'd4;
        step(); step();
        checks++;
        if (lo_rdata !== 32'd42 || hi_rdata !== 32'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: lo=%h hi=%h ready=%b want 2a 0 1", lo_rdata, hi_rdata, req_ready);
        end
        step();
        req_valid = 1'b0; req_op = 4'd0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        end
        step(); step();
        checks++;
        if (lo_rdata !== 32'd0 || hi_rdata !== 32'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: lo=%h hi=%h busy=%b want 0 2 0", lo_rdata, hi_rdata, busy);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd1000; req_src2 = 32'd3;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        for (int i = 0; i < 10; i++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++;
        if (hi_rdata !== 32'd0 || lo_rdata !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b ready=%b want 0 0 0 1",
                     hi_rdata, lo_rdata, busy, req_ready);
        end
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (hi_rdata !== 32'd0 || lo_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_late: hi=%h lo=%h want 0 0", hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_cancel();
        int cyc;
        mt_lo_we = 1'b1; mt_hi_we = 1'b1; mt_wdata = 32'h55;
        step();
        mt_lo_we = 1'b0; mt_hi_we = 1'b0;
        req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd9; req_src2 = 32'd3;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        for (int i = 0; i < 4; i++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
`ifdef MULDIV_CANCEL_EN
        checks++;
        if (busy !== 1'b0 || hi_rdata !== 32'h55 || lo_rdata !== 32'h55) begin
            failures++;
            $display("FAIL cancel: busy=%b hi=%h lo=%h want 0 55 55", busy, hi_rdata, lo_rdata);
        end
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (hi_rdata !== 32'h55 || lo_rdata !== 32'h55) begin
            failures++;
            $display("FAIL cancel_late: hi=%h lo=%h want 55 55", hi_rdata, lo_rdata);
        end
`else
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_ignored: busy=%b want 1", busy);
        end
        cyc = 0;
        while (busy && cyc < 64) begin
            step();
            cyc++;
        end
        checks++;
        if (lo_rdata !== 32'd3 || hi_rdata !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_commit: lo=%h hi=%h busy=%b want 3 0 0", lo_rdata, hi_rdata, busy);
        end
`endif
        // cancel while idle is harmless
        cancel = 1'b1;
        run_op(OP_MULTU, 32'd5, 32'd5, cyc);
        cancel = 1'b0;
`ifdef MULDIV_CANCEL_EN
        checks++;
        if (lo_rdata !== 32'h55 || cyc !== 1) begin
            failures++;
            $display("FAIL cancel_mul: lo=%h cycles=%0d want 55 1", lo_rdata, cyc);
        end
`else
        checks++;
        if (lo_rdata !== 32'd25 || cyc !== MUL_LAT) begin
            failures++;
            $display("FAIL cancel_mul: lo=%h cycles=%0d want 19 %0d", lo_rdata, cyc, MUL_LAT);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_mt_drop();
        test_div();
        test_divzero_mt();
        test_invalid_op();
        test_mt_with_accept();
        test_back_to_back();
        test_reset_mid();
        test_cancel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
